// File: rtl/adau_i2c_init_sequencer.sv
// rtl/adau_i2c_init_sequencer.sv - boot-time ADAU codec register writer over an I2C byte engine
// Waits for codec power-up, then streams START/addr/reg_hi/reg_lo/data/STOP per ROM entry with NACK retries.
module adau_i2c_init_sequencer #(
  parameter int         NUM_CMDS     = 16,
  parameter logic [6:0] DEV_ADDR     = 7'h38,
  parameter int         STARTUP_WAIT = 120000,
  parameter int         MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_index,
  input  logic [23:0] rom_data,
  output logic [1:0]  i2c_cmd,
  output logic [7:0]  i2c_byte,
  output logic        i2c_cmd_valid,
  input  logic        i2c_cmd_ready,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        adau_init_done,
  output logic        adau_init_error
);

  localparam int WAIT_W = ($clog2(STARTUP_WAIT) > 17) ? $clog2(STARTUP_WAIT) : 17;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(STARTUP_WAIT - 1);
  localparam logic [7:0]        LAST_INDEX  = 8'(NUM_CMDS - 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRIES);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;

  localparam logic [2:0] PH_START  = 3'd0;
  localparam logic [2:0] PH_DEV    = 3'd1;
  localparam logic [2:0] PH_REG_HI = 3'd2;
  localparam logic [2:0] PH_REG_LO = 3'd3;
  localparam logic [2:0] PH_DATA   = 3'd4;
  localparam logic [2:0] PH_STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_ABORT_STOP,
    S_ABORT_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        rom_index_q, rom_index_d;
  logic [3:0]        retry_q, retry_d;
  logic [2:0]        phase_q, phase_d;
  logic              done_seen_q, done_seen_d;
  logic              nack_seen_q, nack_seen_d;
  logic              phase_is_write;
  logic              waiting;

  assign phase_is_write = (phase_q >= PH_DEV) && (phase_q <= PH_DATA);
  assign waiting        = (state_q == S_WAIT_DONE) || (state_q == S_ABORT_WAIT);

  // Completion is registered and only captured while waiting, so a pulse
  // coinciding with the acceptance cycle can never be mistaken for this command's.
  always_comb begin
    done_seen_d = i2c_done && waiting;
    nack_seen_d = i2c_done && i2c_nack && (state_q == S_WAIT_DONE) && phase_is_write;
  end

  always_comb begin
    i2c_cmd_valid = 1'b0;
    i2c_cmd       = CMD_START;
    i2c_byte      = 8'h00;
    if (state_q == S_ISSUE) begin
      i2c_cmd_valid = 1'b1;
      case (phase_q)
        PH_START: i2c_cmd = CMD_START;
        PH_DEV: begin
          i2c_cmd  = CMD_WRITE;
          i2c_byte = {DEV_ADDR, 1'b0};
        end
        PH_REG_HI: begin
          i2c_cmd  = CMD_WRITE;
          i2c_byte = rom_data[23:16];
        end
        PH_REG_LO: begin
          i2c_cmd  = CMD_WRITE;
          i2c_byte = rom_data[15:8];
        end
        PH_DATA: begin
          i2c_cmd  = CMD_WRITE;
          i2c_byte = rom_data[7:0];
        end
        default: i2c_cmd = CMD_STOP;
      endcase
    end else if (state_q == S_ABORT_STOP) begin
      i2c_cmd_valid = 1'b1;
      i2c_cmd       = CMD_STOP;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rom_index_d = rom_index_q;
    retry_d     = retry_q;
    phase_d     = phase_q;
    case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_ISSUE;
          phase_d = PH_START;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_ISSUE: begin
        if (i2c_cmd_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_seen_q) begin
          if (nack_seen_q) begin
            state_d = S_ABORT_STOP;
          end else if (phase_q != PH_STOP) begin
            phase_d = phase_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            retry_d = 4'd0;
            if (rom_index_q == LAST_INDEX) begin
              state_d = S_DONE;
            end else begin
              rom_index_d = rom_index_q + 8'd1;
              phase_d     = PH_START;
              state_d     = S_ISSUE;
            end
          end
        end
      end
      S_ABORT_STOP: begin
        if (i2c_cmd_ready) state_d = S_ABORT_WAIT;
      end
      S_ABORT_WAIT: begin
        if (done_seen_q) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            phase_d = PH_START;
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      wait_cnt_q  <= '0;
      rom_index_q <= 8'd0;
      retry_q     <= 4'd0;
      phase_q     <= PH_START;
      done_seen_q <= 1'b0;
      nack_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rom_index_q <= rom_index_d;
      retry_q     <= retry_d;
      phase_q     <= phase_d;
      done_seen_q <= done_seen_d;
      nack_seen_q <= nack_seen_d;
    end
  end

  assign rom_index       = rom_index_q;
  assign adau_init_done  = (state_q == S_DONE);
  assign adau_init_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_adau_i2c_init_sequencer.sv
// tb/tb_adau_i2c_init_sequencer.sv - bench for adau_i2c_init_sequencer
// Ideal I2C engine with stalls, NACK plans and stray pulses against a transaction-level command model.
module tb_adau_i2c_init_sequencer;
  localparam int         NUM_CMDS     = 2;
  localparam int         STARTUP_WAIT = 10;
  localparam int         MAX_RETRIES  = 3;
  localparam logic [6:0] DEV_ADDR     = 7'h38;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_index;
  logic [23:0] rom_data;
  logic [1:0]  i2c_cmd;
  logic [7:0]  i2c_byte;
  logic        i2c_cmd_valid;
  logic        i2c_cmd_ready;
  logic        i2c_done;
  logic        i2c_nack;
  logic        adau_init_done;
  logic        adau_init_error;

  logic [23:0] rom [NUM_CMDS];

  always #5 clk = ~clk;

  always_comb begin
    rom_data = 24'h0;
    if (int'(rom_index) < NUM_CMDS) rom_data = rom[rom_index];
  end

  adau_i2c_init_sequencer #(
    .NUM_CMDS    (NUM_CMDS),
    .DEV_ADDR    (DEV_ADDR),
    .STARTUP_WAIT(STARTUP_WAIT),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_index      (rom_index),
    .rom_data       (rom_data),
    .i2c_cmd        (i2c_cmd),
    .i2c_byte       (i2c_byte),
    .i2c_cmd_valid  (i2c_cmd_valid),
    .i2c_cmd_ready  (i2c_cmd_ready),
    .i2c_done       (i2c_done),
    .i2c_nack       (i2c_nack),
    .adau_init_done (adau_init_done),
    .adau_init_error(adau_init_error)
  );

  int          checks = 0;
  int          failures = 0;
  int          cycle;
  int          end_cycle;
  int          acc_cnt, start_cnt, wr_idx;
  int          stall_at, stall_left, nack_phase;
  bit          pend_done, pend_nack, glitch;
  logic [31:0] nack_mask;
  logic [9:0]  exp_q[$];
  logic [9:0]  log_q[$];
  bit          exp_err;
  int          exp_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] get_log(input int i);
    if (i < log_q.size()) return log_q[i];
    return 10'bx;
  endfunction

  function automatic logic [9:0] get_exp(input int i);
    if (i < exp_q.size()) return exp_q[i];
    return 10'bx;
  endfunction

  function automatic logic [7:0] entry_byte(input int e, input int p);
    case (p)
      1:       return {DEV_ADDR, 1'b0};
      2:       return rom[e][23:16];
      3:       return rom[e][15:8];
      default: return rom[e][7:0];
    endcase
  endfunction

  // Expected accepted-command stream: each attempt is START, writes up to the
  // NACKed one, then STOP; an entry gets MAX_RETRIES further attempts.
  task automatic build_model();
    int  starts, retries, s;
    bit  ok, nacked;
    exp_q.delete();
    exp_err = 0;
    exp_idx = NUM_CMDS - 1;
    starts  = 0;
    for (int e = 0; e < NUM_CMDS && !exp_err; e++) begin
      retries = 0;
      ok      = 0;
      while (!ok && !exp_err) begin
        nacked = 0;
        s      = starts;
        starts++;
        exp_q.push_back({2'd0, 8'h00});
        for (int p = 1; p <= 4 && !nacked; p++) begin
          exp_q.push_back({2'd1, entry_byte(e, p)});
          if (s < 32 && nack_mask[s] && p == nack_phase) nacked = 1;
        end
        exp_q.push_back({2'd2, 8'h00});
        if (!nacked) ok = 1;
        else if (retries < MAX_RETRIES) retries++;
        else begin
          exp_err = 1;
          exp_idx = e;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    i2c_cmd_ready = 1'b0;
    i2c_done      = 1'b0;
    i2c_nack      = 1'b0;
    pend_done     = 0;
    pend_nack     = 0;
    @(posedge clk);
    #1;
    check("rst.rom_index", rom_index, 0);
    check("rst.valid", i2c_cmd_valid, 0);
    check("rst.cmd", i2c_cmd, 0);
    check("rst.byte", i2c_byte, 0);
    check("rst.done", adau_init_done, 0);
    check("rst.error", adau_init_error, 0);
    reset = 1'b0;
    cycle = 0;
  endtask

  task automatic tick();
    i2c_done  = pend_done;
    i2c_nack  = pend_done ? pend_nack : 1'($urandom_range(0, 1));
    pend_done = 0;
    pend_nack = 0;
    if (i2c_cmd_valid && acc_cnt == stall_at && stall_left > 0) begin
      i2c_cmd_ready = 1'b0;
      stall_left--;
    end else begin
      i2c_cmd_ready = i2c_cmd_valid ? 1'b1 : 1'($urandom_range(0, 1));
    end
    if (glitch && i2c_cmd_valid && i2c_cmd_ready && !i2c_done) begin
      i2c_done = 1'b1;
      i2c_nack = 1'($urandom_range(0, 1));
    end
    if (cycle < STARTUP_WAIT) check("startup.valid", i2c_cmd_valid, 0);
    check("done_error_excl", adau_init_done & adau_init_error, 0);
    if (adau_init_done || adau_init_error) check("final.valid", i2c_cmd_valid, 0);
    if (i2c_cmd_valid) check("stream", {i2c_cmd, i2c_byte}, get_exp(acc_cnt));
    if (i2c_cmd_valid && i2c_cmd_ready) begin
      log_q.push_back({i2c_cmd, i2c_byte});
      acc_cnt++;
      pend_done = 1;
      if (i2c_cmd == 2'd1) begin
        wr_idx++;
        pend_nack = (start_cnt > 0 && start_cnt <= 32 && nack_mask[start_cnt-1] && wr_idx == nack_phase);
      end else begin
        if (i2c_cmd == 2'd0) begin
          start_cnt++;
          wr_idx = 0;
        end
        pend_nack = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic run_test(input string name, input int nphase, input logic [31:0] mask,
                          input int s_at, input int s_len, input bit glt, input int abort_at);
    int exp_end;
    nack_phase = nphase;
    nack_mask  = mask;
    stall_at   = s_at;
    stall_left = s_len;
    glitch     = glt;
    build_model();
    do_reset();
    log_q.delete();
    acc_cnt   = 0;
    start_cnt = 0;
    wr_idx    = 0;
    end_cycle = -1;
    while (cycle < 1000) begin
      if (abort_at >= 0 && acc_cnt == abort_at) return;
      if ((adau_init_done || adau_init_error) && end_cycle < 0) end_cycle = cycle;
      if (end_cycle >= 0 && cycle >= end_cycle + 8) break;
      tick();
    end
    exp_end = STARTUP_WAIT + 3 * exp_q.size() + ((s_at < exp_q.size()) ? s_len : 0);
    check({name, ".timeout"}, end_cycle >= 0, 1);
    check({name, ".count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check({name, ".cmd"}, get_log(i), exp_q[i]);
    check({name, ".done"}, adau_init_done, !exp_err);
    check({name, ".error"}, adau_init_error, exp_err);
    check({name, ".rom_index"}, rom_index, exp_idx);
    check({name, ".valid"}, i2c_cmd_valid, 0);
    check({name, ".end_cycle"}, end_cycle, exp_end);
  endtask

  initial begin
    reset         = 1'b1;
    i2c_cmd_ready = 1'b0;
    i2c_done      = 1'b0;
    i2c_nack      = 1'b0;
    glitch        = 0;
    stall_at      = 1000;
    stall_left    = 0;
    nack_mask     = '0;
    nack_phase    = 1;

    rom[0] = 24'h4000_01;
    rom[1] = 24'($urandom);
    run_test("nominal", 1, 32'h0, 1000, 0, 0, -1);
    check("nominal.start", get_log(0), {2'd0, 8'h00});
    check("nominal.w_dev", get_log(1), {2'd1, 8'h70});
    check("nominal.w_hi", get_log(2), {2'd1, 8'h40});
    check("nominal.w_lo", get_log(3), {2'd1, 8'h00});
    check("nominal.w_data", get_log(4), {2'd1, 8'h01});
    check("nominal.stop", get_log(5), {2'd2, 8'h00});
    check("nominal.done_at", end_cycle, 46);

    rom[0] = {8'h40, 16'($urandom)};
    rom[1] = 24'($urandom);
    run_test("stall", 1, 32'h0, 2, 5, 0, -1);
    check("stall.byte", get_log(2), {2'd1, 8'h40});
    check("stall.done_at", end_cycle, 51);

    rom[0] = 24'($urandom);
    rom[1] = 24'($urandom);
    run_test("retry", 1, 32'h6, 1000, 0, 0, -1);
    check("retry.done_at", end_cycle, 64);
    check("retry.done", adau_init_done, 1);

    run_test("exhaust", 4, 32'hffff_ffff, 1000, 0, 1, -1);
    for (int i = 0; i < 20; i++) tick();
    check("exhaust.count", log_q.size(), 24);
    check("exhaust.error", adau_init_error, 1);
    check("exhaust.done", adau_init_done, 0);
    check("exhaust.rom_index", rom_index, 0);
    check("exhaust.valid", i2c_cmd_valid, 0);

    rom[0] = 24'($urandom);
    rom[1] = 24'($urandom);
    run_test("abort", 1, 32'h0, 1000, 0, 0, 8);
    check("abort.rom_index", rom_index, 1);
    check("abort.valid", i2c_cmd_valid, 0);
    run_test("restart", 1, 32'h0, 1000, 0, 0, -1);
    check("restart.done_at", end_cycle, 46);

    for (int r = 0; r < 6; r++) begin
      rom[0] = 24'($urandom);
      rom[1] = 24'($urandom);
      run_test("random", int'($urandom_range(1, 4)), 32'($urandom) & 32'h1f,
               int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
